// File: rtl/vdispatch_seq_pkg.sv
// vdispatch_seq_pkg: shared state encoding, squash-mask helper and width derivation
package vdispatch_seq_pkg;
    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;
    function automatic int vlw_of(input int log2n);
        return log2n + 1;
    endfunction
    function automatic logic [31:0] squash_mask(input int vl, input int n);
        return ((32'd1 << n) - 32'd1) & ~((32'd1 << vl) - 32'd1);
    endfunction
endpackage

// File: rtl/vdispatch_seq.sv
// vdispatch_seq: load/shift/rotate/squash sequencer for the vector dispatcher shifter
module vdispatch_seq
    import vdispatch_seq_pkg::*;
#(
    parameter int NUMLANES     = 4,
    parameter int LOG2NUMLANES = 2,
    parameter int VLW          = vlw_of(LOG2NUMLANES)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VLW-1:0]          in_vl,
    input  logic                    in_rotate,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [LOG2NUMLANES-1:0] out_idx,
    output logic                    sh_load,
    output logic                    sh_shift,
    output logic                    sh_rotate,
    output logic [NUMLANES-1:0]     sh_squash,
    output logic                    busy
);
    state_t                  r_state, w_next;
    logic [VLW-1:0]          r_count;
    logic [LOG2NUMLANES-1:0] r_idx;
    logic [NUMLANES-1:0]     r_squash;
    logic                    r_rot;
    logic                    w_drain, w_last;
    logic [VLW-1:0]          w_vl_eff;
    logic [NUMLANES-1:0]     w_mask;

    assign w_drain  = (r_state == DRAIN);
    assign w_last   = (r_count == VLW'(1));
    assign w_vl_eff = (in_vl > VLW'(NUMLANES)) ? VLW'(NUMLANES) : in_vl;
    assign w_mask   = NUMLANES'(squash_mask(int'(w_vl_eff), NUMLANES));

    always_ff @(posedge clk) begin
        r_state <= !resetn ? IDLE : w_next;
    end

    // flush wins over a coincident handshake in DRAIN
    always_comb begin
        w_next = w_drain ? ((flush || (sh_shift && w_last)) ? IDLE : DRAIN)
                         : (sh_load ? DRAIN : IDLE);
    end

    always_comb begin
        in_ready  = !w_drain && !flush;
        busy      = w_drain;
        out_valid = w_drain;
        out_last  = w_drain && w_last;
        out_idx   = r_idx;
        sh_load   = in_valid && in_ready && (w_vl_eff != '0);
        sh_shift  = w_drain && out_ready && !flush;
        sh_rotate = w_drain && r_rot;
        sh_squash = r_squash;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count  <= '0;
            r_idx    <= '0;
            r_squash <= '0;
            r_rot    <= 1'b0;
        end else if (sh_load) begin
            r_count  <= w_vl_eff;
            r_idx    <= '0;
            r_squash <= w_mask;
            r_rot    <= in_rotate;
        end else if (w_drain && flush) begin
            r_count  <= '0;
            r_squash <= '0;
        end else if (sh_shift) begin
            r_count  <= r_count - VLW'(1);
            r_idx    <= r_idx + LOG2NUMLANES'(1);
            r_squash <= w_last ? '0 : r_squash;
        end
    end
endmodule
